// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, 32x32 register file with write-first bypass,
// immediate extension and an ID/EX register that drives every output.
module id_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        In_Valid,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RF_B_sel,
    input  logic [1:0]  ImmExt,
    input  logic        WB_En,
    input  logic [4:0]  WB_Addr,
    input  logic [31:0] WB_Data,
    output logic        ID_Valid,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B,
    output logic [31:0] Immed,
    output logic [4:0]  Rd_Addr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Func
);

    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] reg_file [32];

    logic        wb_write;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [15:0] imm;

    assign wb_write = WB_En && (WB_Addr != 5'd0);
    assign imm      = ifid_instr[15:0];

    // Flush beats stall so a taken branch can squash an instruction held by a stall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (Flush) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (!Stall) begin
            ifid_instr <= Instr;
            ifid_valid <= In_Valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                reg_file[i] <= '0;
            end
        end else if (wb_write) begin
            reg_file[WB_Addr] <= WB_Data;
        end
    end

    // Write-first: a same-cycle write-back to a source register is forwarded.
    always_comb begin
        rs_addr = ifid_instr[25:21];
        rt_addr = RF_B_sel ? ifid_instr[20:16] : ifid_instr[15:11];

        rs_data = reg_file[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = '0;
        end else if (wb_write && (WB_Addr == rs_addr)) begin
            rs_data = WB_Data;
        end

        rt_data = reg_file[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = '0;
        end else if (wb_write && (WB_Addr == rt_addr)) begin
            rt_data = WB_Data;
        end

        imm_ext = '0;
        case (ImmExt)
            2'b00:   imm_ext = {16'h0000, imm};
            2'b01:   imm_ext = {{16{imm[15]}}, imm};
            2'b10:   imm_ext = {imm, 16'h0000};
            default: imm_ext = {{14{imm[15]}}, imm, 2'b00};
        endcase
    end

    // A stall injects a bubble; data fields still load the decoded values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ID_Valid <= 1'b0;
            RF_A     <= '0;
            RF_B     <= '0;
            Immed    <= '0;
            Rd_Addr  <= '0;
            Opcode   <= '0;
            Func     <= '0;
        end else begin
            ID_Valid <= ifid_valid && !Flush && !Stall;
            RF_A     <= rs_data;
            RF_B     <= rt_data;
            Immed    <= imm_ext;
            Rd_Addr  <= ifid_instr[20:16];
            Opcode   <= ifid_instr[31:26];
            Func     <= ifid_instr[5:0];
        end
    end

endmodule
